cycle_sequencer: RTL and testbench
==================================

Name: cycle_sequencer

Overview:
Timing and control sequencer for the 6502 core. It owns the instruction register and the 3-bit cycle counter that drive the combinational instruction decoder. It consumes the decoder's icyc/rcyc/sinst handshake, runs the fetch/execute loop, and arbitrates reset, NMI and IRQ into the injected interrupt opcode 8'h00. It sits between the data bus input latch and the decoder.

Parameters:
STALL_MAX, 4, EXEC cycles with neither icyc nor rcyc before the opcode is declared illegal (range 2..15)
INT_OP, 8'h00, opcode injected to service reset/NMI/IRQ

Ports:
clk  in  1  core clock
clr  in  1  synchronous active-high reset
db_in  in  8  data bus; holds the opcode during FETCH
icyc  in  1  decoder: advance cycle
rcyc  in  1  decoder: instruction complete
sinst  in  1  decoder: interrupt sequence started
nmi  in  1  raw NMI request, active high, edge-sensitive
irq  in  1  raw IRQ request, active high, level-sensitive
iflag  in  1  status register I bit
inst  out  8  instruction register to decoder
cycle  out  3  cycle counter to decoder
rst_pend  out  1  to decoder clr input
nmi_pend  out  1  to decoder nmi input
irq_pend  out  1  to decoder irq input
exec  out  1  high in EXEC; top level ANDs all decoder control outputs with exec
fetch  out  1  one-cycle pulse when inst is loaded
seq_err  out  1  one-cycle pulse on illegal opcode or cycle overflow

Behaviour:
- Reset (clr=1, sampled at the clk edge): state=RST, inst=8'h00, cycle=0, rst_pend=1, nmi_pend=0, irq_pend=0, irq_blk=0, nmi_q=0, stall=0, exec=0, fetch=0, seq_err=0. clr asserted in any state, including mid-instruction, aborts that instruction and returns to RST on the next edge.
- States: RST, FETCH, EXEC. All outputs are registered.
- RST -> FETCH on the first edge with clr=0.
- FETCH (1 cycle): cycle=0 and stall=0. If rst_pend, nmi_pend or irq_pend is set, inst<=INT_OP; otherwise inst<=db_in. fetch pulses on the transition into EXEC. FETCH -> EXEC.
- EXEC:
  - rcyc=1: EXEC -> FETCH, cycle<=0. rcyc takes priority over icyc when both are set.
  - icyc=1 and cycle<7: cycle<=cycle+1, stall<=0.
  - icyc=1 and cycle==7: wrap is prohibited. seq_err pulses, state goes to FETCH, cycle<=0.
  - Neither icyc nor rcyc: stall<=stall+1. When stall reaches STALL_MAX-1, the opcode is treated as illegal (executes as NOP): seq_err pulses, state goes to FETCH, cycle<=0. The PC is not advanced by this block.
- Interrupt arbitration, priority rst > nmi > irq (same priority as the decoder):
  - nmi_q registers nmi every cycle. A rising edge (nmi & ~nmi_q) sets nmi_pend.
  - irq_pend<=irq & ~iflag & ~irq_blk, evaluated every cycle.
  - sinst=1 while in EXEC, cycle==0 and inst==INT_OP clears the highest-priority pending source: rst_pend, else nmi_pend, else sets irq_blk.
  - irq_blk clears when irq deasserts.
  - A new NMI edge in the same cycle as its sinst clear: the set wins.
- Interrupts are sampled only in FETCH. A request arriving mid-instruction waits for rcyc.
- rst_pend is set only by clr.

Decomposition:
- Shared package cpu_pkg: state enum (RST, FETCH, EXEC), INT_OP, and the opcode localparams already used by the decoder (moved there so both blocks share them).
- Natural sub-module: int_arbiter. It holds the nmi edge detector, the pend flags, irq_blk and the priority clear logic. It outputs the three pend flags plus any_pend.

Test Plan:
- Reset release: clr high 3 cycles then low, db_in=8'hEA. Required: RST, then FETCH, then EXEC with inst=8'h00, rst_pend=1. sinst at cycle 0 clears rst_pend next cycle. Decoder rcyc then returns to FETCH and loads 8'hEA.
- Multi-cycle op: inst=8'hAD with icyc pulsed for 4 cycles, then rcyc. Required: cycle steps 0,1,2,3,4 -> FETCH with cycle=0; fetch pulses once per instruction; seq_err stays 0.
- Simultaneous icyc and rcyc at cycle 2. Required: FETCH, cycle=0; rcyc wins.
- Illegal opcode 8'hFF, no icyc or rcyc, STALL_MAX=4. Required: seq_err pulses after 4 EXEC cycles; next state FETCH.
- NMI edge during EXEC of 8'hAD plus irq=1, iflag=0. Required: next FETCH injects 8'h00 with nmi_pend=1 and irq_pend=1. sinst clears nmi_pend only; the following FETCH injects 8'h00 for IRQ. After that sinst, irq_pend stays 0 until irq drops and reasserts. With iflag=1, irq never sets irq_pend.
- clr asserted at EXEC cycle 3 of 8'h20. Required: next edge in RST with cycle=0, inst=8'h00, rst_pend=1; nmi_pend cleared.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared sequencer state type and opcode constants for the 6502 core
//
// Purpose: types and constants shared by the cycle sequencer and the
// instruction decoder.
// Contents:
//   seq_state_t  sequencer state (RST, FETCH, EXEC)
//   INT_OP       opcode injected to service reset/NMI/IRQ
//   OP_*         opcodes referenced by the decoder and its neighbours

package cpu_pkg;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } seq_state_t;

  localparam logic [7:0] INT_OP     = 8'h00;
  localparam logic [7:0] OP_BRK     = 8'h00;
  localparam logic [7:0] OP_JSR     = 8'h20;
  localparam logic [7:0] OP_RTI     = 8'h40;
  localparam logic [7:0] OP_RTS     = 8'h60;
  localparam logic [7:0] OP_LDA_ABS = 8'hAD;
  localparam logic [7:0] OP_NOP     = 8'hEA;

endpackage

// File: rtl/cycle_sequencer_if.sv
// rtl/cycle_sequencer_if.sv - decoder/bus handshake bundle of the cycle sequencer
//
// Purpose: groups the data bus, decoder handshake and interrupt lines that
// connect the sequencer to the rest of the core.
// Modports:
//   master  environment side: drives db_in, icyc, rcyc, sinst, nmi, irq, iflag
//   slave   sequencer side: drives inst, cycle, *_pend, exec, fetch, seq_err

interface cycle_sequencer_if;

  logic [7:0] db_in;
  logic       icyc;
  logic       rcyc;
  logic       sinst;
  logic       nmi;
  logic       irq;
  logic       iflag;

  logic [7:0] inst;
  logic [2:0] cycle;
  logic       rst_pend;
  logic       nmi_pend;
  logic       irq_pend;
  logic       exec;
  logic       fetch;
  logic       seq_err;

  modport master (
    output db_in, icyc, rcyc, sinst, nmi, irq, iflag,
    input  inst, cycle, rst_pend, nmi_pend, irq_pend, exec, fetch, seq_err
  );

  modport slave (
    input  db_in, icyc, rcyc, sinst, nmi, irq, iflag,
    output inst, cycle, rst_pend, nmi_pend, irq_pend, exec, fetch, seq_err
  );

endinterface

// File: rtl/cycle_sequencer_int_arbiter.sv
// rtl/cycle_sequencer_int_arbiter.sv - reset/NMI/IRQ pending flags and priority clear
//
// Purpose: holds the NMI edge detector, the three pending flags and the IRQ
// block flag; clears the highest-priority source when the decoder starts the
// interrupt sequence.
// Ports:
//   clk, clr   clock, synchronous active-high reset
//   nmi        raw NMI (edge-sensitive)
//   irq        raw IRQ (level-sensitive)
//   iflag      status register I bit
//   sinst_ok   decoder started the interrupt sequence of an injected opcode
//   rst_pend, nmi_pend, irq_pend   registered pending flags
//   any_pend   OR of the pending flags

module int_arbiter (
  input  logic clk,
  input  logic clr,
  input  logic nmi,
  input  logic irq,
  input  logic iflag,
  input  logic sinst_ok,
  output logic rst_pend,
  output logic nmi_pend,
  output logic irq_pend,
  output logic any_pend
);

  logic nmi_q;
  logic irq_blk;
  logic irq_blk_nxt;
  logic nmi_edge;
  logic clr_rst;
  logic clr_nmi;
  logic set_blk;

  assign nmi_edge = nmi & ~nmi_q;

  // Only one source is retired per interrupt sequence, highest priority first.
  assign clr_rst = sinst_ok & rst_pend;
  assign clr_nmi = sinst_ok & ~rst_pend & nmi_pend;
  assign set_blk = sinst_ok & ~rst_pend & ~nmi_pend;

  // The block holds off a still-asserted IRQ line until it drops; irq_pend
  // uses the next value so it falls on the same edge the block is set.
  assign irq_blk_nxt = irq & (irq_blk | set_blk);

  always_ff @(posedge clk) begin
    if (clr) begin
      rst_pend <= 1'b1;
      nmi_pend <= 1'b0;
      irq_pend <= 1'b0;
      irq_blk  <= 1'b0;
      nmi_q    <= 1'b0;
    end else begin
      nmi_q    <= nmi;
      if (clr_rst) begin
        rst_pend <= 1'b0;
      end
      // A fresh edge in the clearing cycle must not be lost.
      nmi_pend <= nmi_edge | (nmi_pend & ~clr_nmi);
      irq_blk  <= irq_blk_nxt;
      irq_pend <= irq & ~iflag & ~irq_blk_nxt;
    end
  end

  assign any_pend = rst_pend | nmi_pend | irq_pend;

endmodule

// File: rtl/cycle_sequencer.sv
// rtl/cycle_sequencer.sv - fetch/execute sequencer owning the instruction register and cycle counter
//
// Purpose: runs the RST/FETCH/EXEC loop, loads the instruction register from
// the data bus (or injects INT_OP when an interrupt is pending), steps the
// cycle counter on the decoder's icyc/rcyc handshake and flags illegal
// opcodes (stall) and cycle-counter overflow.
// Ports:
//   clk   core clock
//   clr   synchronous active-high reset
//   bus   slave modport: db_in, icyc, rcyc, sinst, nmi, irq, iflag in;
//         inst, cycle, rst_pend, nmi_pend, irq_pend, exec, fetch, seq_err out

module cycle_sequencer
  import cpu_pkg::*;
#(
  parameter int         STALL_MAX = 4,
  parameter logic [7:0] INT_OP    = 8'h00
) (
  input  logic               clk,
  input  logic               clr,
  cycle_sequencer_if.slave   bus
);

  localparam logic [3:0] STALL_LAST = 4'(STALL_MAX - 1);

  seq_state_t state, state_nxt;
  logic [7:0] inst_r, inst_nxt;
  logic [2:0] cycle_r, cycle_nxt;
  logic [3:0] stall_r, stall_nxt;
  logic       err_nxt;
  logic       exec_r;
  logic       fetch_r;
  logic       seq_err_r;
  logic       sinst_ok;
  logic       rst_pend;
  logic       nmi_pend;
  logic       irq_pend;
  logic       any_pend;

  // sinst only counts at the first cycle of an injected interrupt opcode.
  assign sinst_ok = bus.sinst & (state == EXEC) & (cycle_r == 3'd0) & (inst_r == INT_OP);

  int_arbiter u_int_arbiter (
    .clk      (clk),
    .clr      (clr),
    .nmi      (bus.nmi),
    .irq      (bus.irq),
    .iflag    (bus.iflag),
    .sinst_ok (sinst_ok),
    .rst_pend (rst_pend),
    .nmi_pend (nmi_pend),
    .irq_pend (irq_pend),
    .any_pend (any_pend)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= RST;
      inst_r    <= 8'h00;
      cycle_r   <= 3'd0;
      stall_r   <= 4'd0;
      exec_r    <= 1'b0;
      fetch_r   <= 1'b0;
      seq_err_r <= 1'b0;
    end else begin
      state     <= state_nxt;
      inst_r    <= inst_nxt;
      cycle_r   <= cycle_nxt;
      stall_r   <= stall_nxt;
      exec_r    <= (state_nxt == EXEC);
      fetch_r   <= (state == FETCH);
      seq_err_r <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    inst_nxt  = inst_r;
    cycle_nxt = cycle_r;
    stall_nxt = stall_r;
    err_nxt   = 1'b0;
    case (state)
      RST: begin
        state_nxt = FETCH;
        cycle_nxt = 3'd0;
        stall_nxt = 4'd0;
      end
      FETCH: begin
        // Interrupts are only sampled here, so a request raised
        // mid-instruction waits for the instruction to complete.
        inst_nxt  = any_pend ? INT_OP : bus.db_in;
        cycle_nxt = 3'd0;
        stall_nxt = 4'd0;
        state_nxt = EXEC;
      end
      EXEC: begin
        if (bus.rcyc) begin
          state_nxt = FETCH;
          cycle_nxt = 3'd0;
        end else if (bus.icyc) begin
          if (cycle_r == 3'd7) begin
            // Counter wrap would re-enter cycle 0 of the same opcode.
            err_nxt   = 1'b1;
            state_nxt = FETCH;
            cycle_nxt = 3'd0;
          end else begin
            cycle_nxt = cycle_r + 3'd1;
            stall_nxt = 4'd0;
          end
        end else if (stall_r == STALL_LAST) begin
          // Decoder never responded: abandon the opcode as a NOP.
          err_nxt   = 1'b1;
          state_nxt = FETCH;
          cycle_nxt = 3'd0;
        end else begin
          stall_nxt = stall_r + 4'd1;
        end
      end
      default: state_nxt = RST;
    endcase
  end

  assign bus.inst     = inst_r;
  assign bus.cycle    = cycle_r;
  assign bus.rst_pend = rst_pend;
  assign bus.nmi_pend = nmi_pend;
  assign bus.irq_pend = irq_pend;
  assign bus.exec     = exec_r;
  assign bus.fetch    = fetch_r;
  assign bus.seq_err  = seq_err_r;

endmodule

// File: tb/tb_cycle_sequencer.sv
// tb/tb_cycle_sequencer.sv - self-checking bench for cycle_sequencer

module tb_cycle_sequencer;
  import cpu_pkg::*;

  // input flags:    {clr, icyc, rcyc, sinst, nmi, irq, iflag}
  // expected flags: {rst_pend, nmi_pend, irq_pend, exec, fetch, seq_err}
  typedef struct packed {
    logic [6:0]  f;
    logic [7:0]  db;
    logic [16:0] e;
  } vec_t;

  logic clk;
  logic clr;
  int   errors;
  int   checks;

  logic [16:0] sbq[$];
  vec_t        vt[$];

  cycle_sequencer_if bus ();

  cycle_sequencer #(
    .STALL_MAX (4),
    .INT_OP    (8'h00)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  function automatic logic [16:0] ex(input logic [7:0] i, input logic [2:0] c, input logic [5:0] fl);
    return {i, c, fl};
  endfunction

  function automatic vec_t v(input logic [6:0] f, input logic [7:0] db,
                             input logic [7:0] i, input logic [2:0] c, input logic [5:0] fl);
    vec_t r;
    r.f  = f;
    r.db = db;
    r.e  = ex(i, c, fl);
    return r;
  endfunction

  task automatic drive(input logic [6:0] f, input logic [7:0] db);
    clr       = f[6];
    bus.icyc  = f[5];
    bus.rcyc  = f[4];
    bus.sinst = f[3];
    bus.nmi   = f[2];
    bus.irq   = f[1];
    bus.iflag = f[0];
    bus.db_in = db;
  endtask

  task automatic compare(input string name);
    logic [16:0] act;
    logic [16:0] want;
    act = {bus.inst, bus.cycle, bus.rst_pend, bus.nmi_pend, bus.irq_pend,
           bus.exec, bus.fetch, bus.seq_err};
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s: got output with empty scoreboard", name);
    end else begin
      want = sbq.pop_front();
      if (act !== want) begin
        errors++;
        $display("FAIL %s: got inst=%h cycle=%0d flags=%b, want inst=%h cycle=%0d flags=%b",
                 name, act[16:9], act[8:6], act[5:0], want[16:9], want[8:6], want[5:0]);
      end
    end
  endtask

  task automatic step(input string name, input logic [6:0] f, input logic [7:0] db,
                      input logic [16:0] e);
    drive(f, db);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    compare(name);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    drive(7'b1000000, OP_NOP);

    // reset release, rst service, NOP fetch
    vt.push_back(v(7'b1000000, OP_NOP, 8'h00, 3'd0, 6'b100000));
    vt.push_back(v(7'b1000000, OP_NOP, 8'h00, 3'd0, 6'b100000));
    vt.push_back(v(7'b1000000, OP_NOP, 8'h00, 3'd0, 6'b100000));
    vt.push_back(v(7'b0000000, OP_NOP, 8'h00, 3'd0, 6'b100000));
    vt.push_back(v(7'b0000000, OP_NOP, 8'h00, 3'd0, 6'b100110));
    vt.push_back(v(7'b0001000, OP_NOP, 8'h00, 3'd0, 6'b000100));
    vt.push_back(v(7'b0010000, OP_NOP, 8'h00, 3'd0, 6'b000000));
    vt.push_back(v(7'b0000000, OP_NOP, OP_NOP, 3'd0, 6'b000110));
    // multi-cycle LDA abs
    vt.push_back(v(7'b0010000, OP_NOP, OP_NOP, 3'd0, 6'b000000));
    vt.push_back(v(7'b0000000, OP_LDA_ABS, OP_LDA_ABS, 3'd0, 6'b000110));
    vt.push_back(v(7'b0100000, OP_LDA_ABS, OP_LDA_ABS, 3'd1, 6'b000100));
    vt.push_back(v(7'b0100000, OP_LDA_ABS, OP_LDA_ABS, 3'd2, 6'b000100));
    vt.push_back(v(7'b0100000, OP_LDA_ABS, OP_LDA_ABS, 3'd3, 6'b000100));
    vt.push_back(v(7'b0100000, OP_LDA_ABS, OP_LDA_ABS, 3'd4, 6'b000100));
    vt.push_back(v(7'b0010000, OP_LDA_ABS, OP_LDA_ABS, 3'd0, 6'b000000));
    // icyc and rcyc together at cycle 2
    vt.push_back(v(7'b0000000, OP_LDA_ABS, OP_LDA_ABS, 3'd0, 6'b000110));
    vt.push_back(v(7'b0100000, OP_LDA_ABS, OP_LDA_ABS, 3'd1, 6'b000100));
    vt.push_back(v(7'b0100000, OP_LDA_ABS, OP_LDA_ABS, 3'd2, 6'b000100));
    vt.push_back(v(7'b0110000, OP_LDA_ABS, OP_LDA_ABS, 3'd0, 6'b000000));
    // NMI edge + IRQ during LDA, then NMI and IRQ services
    vt.push_back(v(7'b0000000, OP_LDA_ABS, OP_LDA_ABS, 3'd0, 6'b000110));
    vt.push_back(v(7'b0100110, OP_LDA_ABS, OP_LDA_ABS, 3'd1, 6'b011100));
    vt.push_back(v(7'b0010110, OP_LDA_ABS, OP_LDA_ABS, 3'd0, 6'b011000));
    vt.push_back(v(7'b0000010, OP_LDA_ABS, 8'h00, 3'd0, 6'b011110));
    vt.push_back(v(7'b0001010, OP_LDA_ABS, 8'h00, 3'd0, 6'b001100));
    vt.push_back(v(7'b0010010, OP_LDA_ABS, 8'h00, 3'd0, 6'b001000));
    vt.push_back(v(7'b0000010, OP_LDA_ABS, 8'h00, 3'd0, 6'b001110));
    vt.push_back(v(7'b0001010, OP_LDA_ABS, 8'h00, 3'd0, 6'b000100));
    vt.push_back(v(7'b0010010, OP_LDA_ABS, 8'h00, 3'd0, 6'b000000));
    vt.push_back(v(7'b0000010, OP_LDA_ABS, OP_LDA_ABS, 3'd0, 6'b000110));
    vt.push_back(v(7'b0010000, OP_LDA_ABS, OP_LDA_ABS, 3'd0, 6'b000000));
    vt.push_back(v(7'b0000010, OP_NOP, OP_NOP, 3'd0, 6'b001110));
    // iflag masks IRQ
    vt.push_back(v(7'b0010011, OP_NOP, OP_NOP, 3'd0, 6'b000000));
    vt.push_back(v(7'b0000011, OP_NOP, OP_NOP, 3'd0, 6'b000110));
    vt.push_back(v(7'b0010011, OP_NOP, OP_NOP, 3'd0, 6'b000000));

    for (int i = 0; i < vt.size(); i++) begin
      step($sformatf("vec%0d", i), vt[i].f, vt[i].db, vt[i].e);
    end

    // illegal opcode: four silent EXEC cycles, then seq_err and refetch
    step("ill_fetch", 7'b0000000, 8'hFF, ex(8'hFF, 3'd0, 6'b000110));
    for (int i = 0; i < 4; i++) begin
      step($sformatf("ill_stall%0d", i), 7'b0000000, 8'hFF,
           ex(8'hFF, 3'd0, (i == 3) ? 6'b000001 : 6'b000100));
    end
    step("ill_refetch", 7'b0000000, OP_LDA_ABS, ex(OP_LDA_ABS, 3'd0, 6'b000110));

    // cycle counter overflow at cycle 7
    for (int i = 1; i < 8; i++) begin
      step($sformatf("ovf_cyc%0d", i), 7'b0100000, OP_LDA_ABS, ex(OP_LDA_ABS, 3'(i), 6'b000100));
    end
    step("ovf_err", 7'b0100000, OP_LDA_ABS, ex(OP_LDA_ABS, 3'd0, 6'b000001));
    step("jsr_fetch", 7'b0000000, OP_JSR, ex(OP_JSR, 3'd0, 6'b000110));

    // clr at cycle 3 of JSR with an NMI pending
    for (int i = 1; i < 4; i++) begin
      step($sformatf("jsr_cyc%0d", i), 7'b0100100, OP_JSR, ex(OP_JSR, 3'(i), 6'b010100));
    end
    step("jsr_clr", 7'b1000000, OP_JSR, ex(8'h00, 3'd0, 6'b100000));
    step("clr_rel", 7'b0000000, OP_JSR, ex(8'h00, 3'd0, 6'b100000));
    step("rst_inject", 7'b0000000, OP_JSR, ex(8'h00, 3'd0, 6'b100110));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
